pipe_tick_ctrl: RTL
===================

Name: pipe_tick_ctrl

Overview:
- Sequencing controller for the two-stage datapath (Stage1 → pipeline register PR → Stage2).
- Replaces the derived slow clock with a single-domain, programmable clock-enable "tick" on fast_clk.
- Tracks per-stage valid bits, generates PR/S2 load enables, applies valid/ready backpressure at both ends, and supports flush.
- Sits between the Stage1 producer and the Stage2 result consumer; the datapath registers consume pr_en/s2_en.

Parameters:
- DIV_W, 4, width of divide-ratio configuration.
- DIV_RST, 4, divide ratio loaded at reset (tick every DIV_RST fast_clk cycles).
- STALL_W, 16, width of saturating stall counter.

Ports:
- fast_clk  in  1  single system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cfg_div  in  DIV_W  new divide ratio; 0 treated as 1.
- cfg_load  in  1  1-cycle pulse; latch cfg_div.
- flush  in  1  discard all in-flight data.
- in_valid  in  1  Stage1 output valid.
- in_ready  out  1  PR accepts Stage1 data this cycle.
- pr_en  out  1  load enable for PR (= in_valid & in_ready).
- s2_en  out  1  load enable for Stage2 result register.
- out_valid  out  1  Stage2 result valid.
- out_ready  in  1  consumer accepts result.
- tick  out  1  advance pulse, 1 fast_clk wide.
- occupancy  out  2  number of valid stages (v_pr + v_s2), 0..2.
- stall_cnt  out  STALL_W  ticks where a valid PR could not advance.

Behaviour:
- Reset (rst=1 at posedge): div_q=DIV_RST, cnt=0, v_pr=0, v_s2=0, stall_cnt=0.
- Reset outputs: tick=0, in_ready=0, pr_en=0, s2_en=0, out_valid=0, occupancy=0.
- Divider: div_eff = (div_q==0) ? 1 : div_q.
  - cnt counts 0..div_eff-1 and wraps.
  - tick = (cnt==div_eff-1) & ~flush, combinational from cnt.
  - div_eff=1 gives tick every cycle.
- cfg_load: div_q<=cfg_div, cnt<=0, tick suppressed that cycle. If concurrent with flush, both actions apply.
- Output handshake (every fast_clk, not tick-gated):
  - out_valid = v_s2.
  - pop = v_s2 & out_ready.
- s2_en = tick & v_pr & (~v_s2 | out_ready). All terms are combinational, so out_ready feeds in_ready combinationally (documented path).
- in_ready = tick & (~v_pr | s2_en).
- pr_en = in_valid & in_ready.
- Next state:
  - v_pr <= pr_en | (v_pr & ~s2_en).
  - v_s2 <= s2_en | (v_s2 & ~pop).
- Simultaneous pop and s2_en in the same cycle: v_s2 stays 1 (new result replaces the popped one).
- Latency: data accepted on tick k → s2_en on tick k+1 → out_valid the cycle after tick k+1, provided there is no backpressure.
- Stall: when tick & v_pr & ~s2_en, stall_cnt increments and saturates at all-ones. Cleared only by rst, not by flush.
- Flush (highest priority after rst):
  - Same cycle: tick, in_ready, pr_en, s2_en forced 0.
  - Next cycle: v_pr=0, v_s2=0, cnt=0.
  - out_valid may be 1 during the flush cycle; a pop in that cycle is legal and the result is consumed.
- Reset mid-operation discards all state regardless of handshake status.
- occupancy = v_pr + v_s2, registered-state derived.

Test Plan:
- Reset, DIV_RST=4, in_valid=1, out_ready=1:
  - tick at cycles 3, 7, 11…
  - pr_en at cycle 3, s2_en at cycle 7, out_valid from cycle 8.
  - Steady throughput 1 result per 4 cycles; stall_cnt stays 0.
- Backpressure: out_ready=0 with continuous input:
  - occupancy reaches 2 after 2 ticks.
  - in_ready stays 0 on later ticks; stall_cnt increments by 1 per tick.
  - Raise out_ready: pop, then PR advances on the next tick.
- cfg_load with cfg_div=0 mid-run:
  - tick suppressed in the load cycle, then asserted every cycle.
  - With out_ready=1, pr_en/s2_en pulse every cycle.
- cfg_load with cfg_div=2: next tick exactly 2 cycles after the load cycle.
- Flush with occupancy=2:
  - During the flush cycle: no tick, no enables.
  - Next cycle: occupancy=0, out_valid=0, cnt=0.
  - First tick at div_eff-1 cycles later; stall_cnt retained.
- Assert stall 2^STALL_W+3 ticks (STALL_W overridden to 4 in the bench): stall_cnt saturates at 15 and does not wrap.

Source files
------------

// File: rtl/pipe_tick_ctrl.sv
// Sequencing controller for a two-stage datapath: a programmable clock-enable
// tick on the single fast clock drives PR/Stage2 load enables with valid/ready flow control.
module pipe_tick_ctrl #(
  parameter int DIV_W   = 4,
  parameter int DIV_RST = 4,
  parameter int STALL_W = 16
) (
  input  logic               fast_clk,
  input  logic               rst,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic               cfg_load,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               pr_en,
  output logic               s2_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               tick,
  output logic [1:0]         occupancy,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam logic [DIV_W-1:0] DIV_RST_V = DIV_W'(DIV_RST);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] cnt_last;
  logic             wrap;
  logic             v_pr;
  logic             v_s2;
  logic             pop;
  logic             stall;

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (&v) ? v : v + STALL_W'(1);
  endfunction

  // A programmed ratio of zero behaves as divide-by-one.
  assign div_eff  = (div_q == '0) ? DIV_W'(1) : div_q;
  assign cnt_last = div_eff - DIV_W'(1);
  assign wrap     = (cnt >= cnt_last);

  // Stage boundary: tick and load enables, all combinational from registered state.
  assign tick      = wrap & ~flush & ~cfg_load & ~rst;
  assign s2_en     = tick & v_pr & (~v_s2 | out_ready);
  assign in_ready  = tick & (~v_pr | s2_en);
  assign pr_en     = in_valid & in_ready;
  assign pop       = v_s2 & out_ready;
  assign out_valid = v_s2;
  assign occupancy = {1'b0, v_pr} + {1'b0, v_s2};
  assign stall     = tick & v_pr & ~s2_en;

  // Stage boundary: divider, valid bits and stall counter registers.
  always_ff @(posedge fast_clk) begin
    if (rst) begin
      div_q     <= DIV_RST_V;
      cnt       <= '0;
      v_pr      <= 1'b0;
      v_s2      <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (cfg_load)
        div_q <= cfg_div;

      if (flush || cfg_load || wrap)
        cnt <= '0;
      else
        cnt <= cnt + DIV_W'(1);

      if (flush) begin
        v_pr <= 1'b0;
        v_s2 <= 1'b0;
      end else begin
        v_pr <= pr_en | (v_pr & ~s2_en);
        v_s2 <= s2_en | (v_s2 & ~pop);
      end

      if (stall)
        stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule
